// File: rtl/mdu_div_sched_pkg.sv
// Shared CPU header slice: divider scheduler state encoding and result width.
`default_nettype none

package mdu_div_sched_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_RES_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN1 = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN2 = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // True while the shared divider holds (or is about to receive) an operation.
  function automatic logic div_in_flight(input div_state_e s);
    return (s == ST_RUN1) || (s == ST_GAP) || (s == ST_RUN2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_div_sched.sv
// Schedules two issue slots onto one shared iterative divider, slot 1 first,
// and holds both results until the EXE bundle advances.
`default_nettype none

module mdu_div_sched
  import mdu_div_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req1,
  input  logic                 sign1,
  input  logic [XLEN-1:0]      a1,
  input  logic [XLEN-1:0]      b1,
  input  logic                 req2,
  input  logic                 sign2,
  input  logic [XLEN-1:0]      a2,
  input  logic [XLEN-1:0]      b2,
  input  logic                 adv,
  output logic                 done1,
  output logic                 done2,
  output logic [DIV_RES_W-1:0] res1,
  output logic [DIV_RES_W-1:0] res2,
  output logic                 busy,
  output logic                 div_start,
  output logic                 div_signed,
  output logic [XLEN-1:0]      div_x,
  output logic [XLEN-1:0]      div_y,
  output logic                 div_abort,
  input  logic                 div_valid,
  input  logic [DIV_RES_W-1:0] div_res
);

  div_state_e           state_q, state_d;
  logic                 done1_q, done1_d;
  logic                 done2_q, done2_d;
  logic [DIV_RES_W-1:0] res1_q, res1_d;
  logic [DIV_RES_W-1:0] res2_q, res2_d;
  logic                 div_start_q, div_start_d;
  logic                 div_abort_q, div_abort_d;
  logic                 div_signed_q, div_signed_d;
  logic [XLEN-1:0]      div_x_q, div_x_d;
  logic [XLEN-1:0]      div_y_q, div_y_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done1_q      <= 1'b0;
      done2_q      <= 1'b0;
      res1_q       <= '0;
      res2_q       <= '0;
      div_start_q  <= 1'b0;
      div_abort_q  <= 1'b0;
      div_signed_q <= 1'b0;
      div_x_q      <= '0;
      div_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      done1_q      <= done1_d;
      done2_q      <= done2_d;
      res1_q       <= res1_d;
      res2_q       <= res2_d;
      div_start_q  <= div_start_d;
      div_abort_q  <= div_abort_d;
      div_signed_q <= div_signed_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
    end
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req1)      state_d = ST_RUN1;
          else if (req2) state_d = ST_RUN2;
        end
        ST_RUN1: begin
          if (div_valid) state_d = req2 ? ST_GAP : ST_DONE;
        end
        ST_GAP:  state_d = ST_RUN2;
        ST_RUN2: begin
          if (div_valid) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (adv) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: operand loads, start/abort pulses and result capture.
  always_comb begin
    done1_d      = done1_q;
    done2_d      = done2_q;
    res1_d       = res1_q;
    res2_d       = res2_q;
    div_signed_d = div_signed_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_start_d  = 1'b0;
    div_abort_d  = 1'b0;
    if (flush) begin
      done1_d     = 1'b0;
      done2_d     = 1'b0;
      div_abort_d = div_in_flight(state_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req1) begin
            div_x_d      = a1;
            div_y_d      = b1;
            div_signed_d = sign1;
            div_start_d  = 1'b1;
          end else if (req2) begin
            div_x_d      = a2;
            div_y_d      = b2;
            div_signed_d = sign2;
            div_start_d  = 1'b1;
          end
        end
        ST_RUN1: begin
          if (div_valid) begin
            res1_d  = div_res;
            done1_d = 1'b1;
          end
        end
        ST_GAP: begin
          div_x_d      = a2;
          div_y_d      = b2;
          div_signed_d = sign2;
          div_start_d  = 1'b1;
        end
        ST_RUN2: begin
          if (div_valid) begin
            res2_d  = div_res;
            done2_d = 1'b1;
          end
        end
        ST_DONE: begin
          if (adv) begin
            done1_d = 1'b0;
            done2_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done1      = done1_q;
  assign done2      = done2_q;
  assign res1       = res1_q;
  assign res2       = res2_q;
  assign busy       = (state_q != ST_IDLE);
  assign div_start  = div_start_q;
  assign div_abort  = div_abort_q;
  assign div_signed = div_signed_q;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_div_sched.sv
// Randomized bench for mdu_div_sched with a behavioural shared divider and
// a bundle-level reference model of the expected results and timing.
`default_nettype none

module tb_mdu_div_sched;
  import mdu_div_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, adv;
  logic        req1, sign1, req2, sign2;
  logic [31:0] a1, b1, a2, b2;
  logic        done1, done2, busy, div_start, div_signed, div_abort, div_valid;
  logic [63:0] res1, res2, div_res;
  logic [31:0] div_x, div_y;

  mdu_div_sched dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req1(req1), .sign1(sign1), .a1(a1), .b1(b1),
    .req2(req2), .sign2(sign2), .a2(a2), .b2(b2),
    .adv(adv), .done1(done1), .done2(done2), .res1(res1), .res2(res2),
    .busy(busy), .div_start(div_start), .div_signed(div_signed),
    .div_x(div_x), .div_y(div_y), .div_abort(div_abort),
    .div_valid(div_valid), .div_res(div_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Divider arithmetic: {remainder, quotient}; divide-by-zero gives {x, all ones}.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint q, r, sx, sy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural shared divider plus event log.
  int          cyc = 0;
  bit          dv_run = 0;
  int          dv_cnt = 0;
  int          dv_lat = 0;
  logic [31:0] cx, cy;
  logic        cs;
  int          scyc[$];
  int          vcyc[$];
  int          aborts = 0;
  bit          force_v = 0;
  logic [63:0] force_res;
  logic [63:0] m_res1 = '0;
  logic [63:0] m_res2 = '0;

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    div_valid = 1'b0;
    if (div_abort) begin
      aborts++;
      dv_run = 0;
    end
    if (dv_run) begin
      check_val("div_x_stable", div_x, cx);
      check_val("div_y_stable", div_y, cy);
      check_val("div_sign_stable", div_signed, cs);
      if (dv_cnt == 0) begin
        div_valid = 1'b1;
        div_res   = ref_div(cs, cx, cy);
        dv_run    = 0;
        vcyc.push_back(cyc);
      end else begin
        dv_cnt--;
      end
    end
    if (div_start) begin
      scyc.push_back(cyc);
      cx = div_x; cy = div_y; cs = div_signed;
      dv_run = 1;
      dv_cnt = dv_lat;
    end
    if (force_v) begin
      div_valid = 1'b1;
      div_res   = force_res;
    end
  endtask

  task automatic run_bundle(input bit r1, input bit s1, input logic [31:0] x1, input logic [31:0] y1,
                            input bit r2, input bit s2, input logic [31:0] x2, input logic [31:0] y2,
                            input int lat, input bit chatter);
    int issue, d1c, d2c, n0;
    bit ok;
    logic [63:0] e1, e2;
    dv_lat = lat;
    scyc.delete();
    vcyc.delete();
    n0 = aborts;
    e1 = r1 ? ref_div(s1, x1, y1) : m_res1;
    e2 = r2 ? ref_div(s2, x2, y2) : m_res2;
    req1 = r1; sign1 = s1; a1 = x1; b1 = y1;
    req2 = r2; sign2 = s2; a2 = x2; b2 = y2;
    issue = cyc;
    d1c = -1; d2c = -1; ok = 0;
    for (int t = 0; t < 300; t++) begin
      cycle();
      adv = 1'b0;
      if (t == 0 && r1) check_val("res1_retained", res1, m_res1);
      if (done1 && d1c < 0) d1c = cyc;
      if (done2 && d2c < 0) d2c = cyc;
      if ((!r1 || done1) && (!r2 || done2)) begin
        ok = 1;
        break;
      end
      if (chatter) adv = ($urandom_range(0, 3) == 0);
    end
    adv = 1'b0;
    check_val("bundle_timeout", ok, 1);
    check_val("start_count", scyc.size(), int'(r1) + int'(r2));
    if (scyc.size() > 0) check_val("start_latency", scyc[0] - issue, 1);
    if (r1 && vcyc.size() > 0) check_val("done1_latency", d1c - vcyc[0], 1);
    if (r2 && vcyc.size() > 0) check_val("done2_latency", d2c - vcyc[vcyc.size()-1], 1);
    if (r1 && r2 && scyc.size() == 2 && vcyc.size() > 0) check_val("slot2_gap", scyc[1] - vcyc[0], 2);
    check_val("done1", done1, r1);
    check_val("done2", done2, r2);
    check_val("res1", res1, e1);
    check_val("res2", res2, e2);
    check_val("busy_done", busy, 1);
    check_val("no_abort", aborts - n0, 0);
    m_res1 = e1;
    m_res2 = e2;
    // Hold in DONE with stray divider pulses that must be ignored.
    repeat ($urandom_range(0, 2)) begin
      force_v = $urandom_range(0, 1);
      force_res = {$urandom, $urandom};
      cycle();
      force_v = 1'b0;
      check_val("hold_res1", res1, e1);
      check_val("hold_res2", res2, e2);
      check_val("hold_done", {done1, done2}, {r1, r2});
    end
    adv = 1'b1;
    cycle();
    adv = 1'b0; req1 = 1'b0; req2 = 1'b0;
    check_val("idle_after_adv", {busy, done1, done2}, 3'b000);
  endtask

  initial begin
    int found;
    reset = 1'b1; flush = 1'b0; adv = 1'b0;
    req1 = 1'b0; sign1 = 1'b0; a1 = '0; b1 = '0;
    req2 = 1'b0; sign2 = 1'b0; a2 = '0; b2 = '0;
    div_valid = 1'b0; div_res = '0;
    repeat (3) cycle();
    check_val("rst_flags", {busy, done1, done2, div_start, div_abort, div_signed}, 6'b0);
    check_val("rst_res1", res1, 64'd0);
    check_val("rst_res2", res2, 64'd0);
    check_val("rst_div_xy", {div_x, div_y}, 64'd0);
    reset = 1'b0;
    cycle();

    // Slot 1 only, signed 100/7.
    run_bundle(1, 1, 32'd100, 32'd7, 0, 0, 32'd0, 32'd0, 4, 0);
    check_val("s1_100_7", res1, {32'd2, 32'd14});

    // Both slots: unsigned 0xFFFFFFFF/16 then signed -7/2.
    run_bundle(1, 0, 32'hFFFF_FFFF, 32'd16, 1, 1, 32'hFFFF_FFF9, 32'd2, 3, 1);
    check_val("both_res1", res1, {32'd15, 32'h0FFF_FFFF});
    check_val("both_res2", res2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Slot 2 only, divide by zero.
    run_bundle(0, 1, 32'd0, 32'd0, 1, 1, 32'd123, 32'd0, 2, 0);
    check_val("s2_div0", res2, {32'd123, 32'hFFFF_FFFF});

    // Back-to-back bundles.
    run_bundle(1, 0, 32'd50, 32'd5, 0, 0, 32'd0, 32'd0, 1, 0);
    run_bundle(1, 0, 32'd77, 32'd10, 0, 0, 32'd0, 32'd0, 0, 0);

    // Flush during RUN1, 5 cycles after start; a late valid must be ignored.
    dv_lat = 20;
    scyc.delete();
    req1 = 1'b1; sign1 = 1'b0; a1 = 32'd1000; b1 = 32'd3;
    cycle();
    check_val("flush1_started", scyc.size(), 1);
    repeat (5) cycle();
    flush = 1'b1; req1 = 1'b0;
    cycle();
    flush = 1'b0;
    check_val("flush1_abort", div_abort, 1);
    check_val("flush1_idle", {busy, done1, done2}, 3'b000);
    cycle();
    check_val("flush1_abort_pulse", div_abort, 0);
    force_v = 1'b1; force_res = 64'hDEAD_BEEF_0BAD_F00D;
    cycle();
    force_v = 1'b0;
    cycle();
    check_val("late_valid_ignored", {busy, done1, done2}, 3'b000);
    check_val("late_valid_res1", res1, m_res1);
    check_val("flush1_no_restart", scyc.size(), 1);

    // Flush coincident with the slot 2 div_valid.
    dv_lat = 2;
    scyc.delete(); vcyc.delete();
    req1 = 1'b1; sign1 = 1'b1; a1 = 32'd9; b1 = 32'd4;
    req2 = 1'b1; sign2 = 1'b0; a2 = 32'd8; b2 = 32'd3;
    found = 0;
    for (int t = 0; t < 100; t++) begin
      cycle();
      if (div_valid && scyc.size() == 2) begin
        found = 1;
        flush = 1'b1; req1 = 1'b0; req2 = 1'b0;
        break;
      end
    end
    check_val("flush2_reached", found, 1);
    m_res1 = ref_div(1'b1, 32'd9, 32'd4);
    cycle();
    flush = 1'b0; req1 = 1'b0; req2 = 1'b0;
    check_val("flush2_abort", div_abort, 1);
    check_val("flush2_done", {done1, done2}, 2'b00);
    check_val("flush2_busy", busy, 0);
    check_val("flush2_res2", res2, m_res2);
    cycle();
    check_val("flush2_idle", {busy, div_abort}, 2'b00);

    // Randomized bundles.
    for (int i = 0; i < 40; i++) begin
      bit rr1, rr2, ss1, ss2;
      logic [31:0] xa, ya, xb, yb;
      do begin
        rr1 = $urandom_range(0, 1);
        rr2 = $urandom_range(0, 1);
      end while (!rr1 && !rr2);
      ss1 = $urandom_range(0, 1);
      ss2 = $urandom_range(0, 1);
      xa = $urandom;
      xb = $urandom;
      ya = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : $urandom);
      yb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? 32'(-$urandom_range(1, 20)) : $urandom);
      run_bundle(rr1, ss1, xa, ya, rr2, ss2, xb, yb, $urandom_range(0, 6), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
